// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC register, credit-limited fetch requests, and an
// in-order prefetch queue presenting {instr, pc} to decode. Redirects drain stale responses.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t        state, state_n;
  logic [31:0]   pc, pc_n;
  logic [CW-1:0] outstanding, outstanding_n, count, count_n, drop, drop_n;
  logic [PW-1:0] head, tail;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic        accept, rsp_take, push, pop, clear;
  logic [31:0] rsp_pc;
  logic        unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  assign imem_req_valid = (state == FETCH) && (({1'b0, outstanding} + {1'b0, count}) < DEPTH_C);
  assign imem_req_addr  = pc;
  assign dec_valid      = (count != '0) && (state == FETCH);
  assign dec_instr      = (count != '0) ? q_instr[head] : '0;
  assign dec_pc         = (count != '0) ? q_pc[head]    : '0;

  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && (outstanding != '0);
  assign push     = (state == FETCH) && rsp_take && !redirect_valid;
  assign pop      = dec_valid && dec_ready;
  assign clear    = redirect_valid;
  // In FETCH every outstanding request is live and consecutive, so the oldest
  // one (the one answering now) sits outstanding words behind pc.
  assign rsp_pc   = pc - 32'({outstanding, 2'b00});

  always_comb begin
    state_n       = state;
    pc_n          = accept ? pc + 32'd4 : pc;
    outstanding_n = outstanding + CW'(accept) - CW'(rsp_take);
    drop_n        = drop;
    count_n       = count + CW'(push) - CW'(pop);
    if (state == DRAIN) begin
      drop_n = drop - CW'(rsp_take);
      if (drop_n == '0) state_n = FETCH;
    end
    if (redirect_valid) begin
      pc_n    = {redirect_pc[31:2], 2'b00};
      drop_n  = outstanding_n;
      count_n = '0;
      state_n = (outstanding_n != '0) ? DRAIN : FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      outstanding <= '0;
      count       <= '0;
      drop        <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      outstanding <= outstanding_n;
      count       <= count_n;
      drop        <= drop_n;
      if (clear)     head <= '0;
      else if (pop)  head <= head + 1'b1;
      if (clear)     tail <= '0;
      else if (push) tail <= tail + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail] <= imem_rsp_data;
      q_pc[tail]    <= rsp_pc;
    end
  end
endmodule
